// File: rtl/fp_op_sequencer.sv
// rtl/fp_op_sequencer.sv - issue/latency/writeback sequencer for the multi-cycle FP unit.
// Optional performance counters are compiled in with `define FPSEQ_PERF_EN.
module fp_op_sequencer #(
  parameter int LAT_ADD = 3,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [1:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic        flush_e,
  output logic        issue_ready,
  output logic        fpu_start,
  output logic [1:0]  fpu_op,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  output logic        raw_stall,
  output logic        struct_stall,
  input  logic        int_wb_valid,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
`ifdef FPSEQ_PERF_EN
  output logic [31:0] perf_busy_cycles,
  output logic [31:0] perf_wb_wait_cycles,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [1:0]  op_q;
  logic [4:0]  rd_q;
  logic        accept;

  // The counter is loaded with latency-1 so that cnt==0 marks the last BUSY cycle.
  function automatic logic [2:0] lat_m1(input logic [1:0] op);
    case (op)
      2'b10:   lat_m1 = 3'(LAT_MUL - 1);
      2'b11:   lat_m1 = 3'(LAT_DIV - 1);
      default: lat_m1 = 3'(LAT_ADD - 1);
    endcase
  endfunction

  assign accept = (state == IDLE) && issue_valid && !flush_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      op_q      <= 2'd0;
      rd_q      <= 5'd0;
      fpu_start <= 1'b0;
    end else begin
      fpu_start <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q      <= issue_op;
            rd_q      <= issue_rd;
            cnt       <= lat_m1(issue_op);
            fpu_start <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
          else             state <= WB;
        end
        WB: begin
          // Integer writeback owns the port; the FP result simply waits.
          if (!int_wb_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign issue_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign fpu_op       = op_q;
  assign wb_rd        = rd_q;
  assign wb_valid     = (state == WB) && !int_wb_valid;
  assign struct_stall = issue_valid && !issue_ready;
  assign raw_stall    = busy && (rd_q != 5'd0) && ((rs1_d == rd_q) || (rs2_d == rd_q));

`ifdef FPSEQ_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles    <= 32'd0;
      perf_wb_wait_cycles <= 32'd0;
    end else begin
      if (busy) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state == WB) && int_wb_valid) perf_wb_wait_cycles <= perf_wb_wait_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb/tb_fp_op_sequencer.sv - scoreboard bench for fp_op_sequencer.
module tb_fp_op_sequencer;

  localparam int LAT_ADD = 3;
  localparam int LAT_MUL = 4;
  localparam int LAT_DIV = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_op = 2'd0;
  logic [4:0]  issue_rd = 5'd0;
  logic        flush_e = 1'b0;
  logic        issue_ready;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [4:0]  rs1_d = 5'd0;
  logic [4:0]  rs2_d = 5'd0;
  logic        raw_stall;
  logic        struct_stall;
  logic        int_wb_valid = 1'b0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        busy;
`ifdef FPSEQ_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [31:0] perf_wb_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int starts_seen = 0;
  int starts_exp = 0;
  logic [4:0] exp_q[$];

  fp_op_sequencer #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rd(issue_rd), .flush_e(flush_e), .issue_ready(issue_ready),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .rs1_d(rs1_d), .rs2_d(rs2_d),
    .raw_stall(raw_stall), .struct_stall(struct_stall), .int_wb_valid(int_wb_valid),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
`ifdef FPSEQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_wb_wait_cycles(perf_wb_wait_cycles),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [1:0] op);
    case (op)
      2'b10:   return LAT_MUL;
      2'b11:   return LAT_DIV;
      default: return LAT_ADD;
    endcase
  endfunction

  // Grants and start pulses are observed mid-cycle, where all inputs are stable.
  always @(negedge clk) begin
    if (fpu_start) starts_seen++;
    if (wb_valid) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
      else check("wb_rd", 32'(wb_rd), 32'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input int waits, input logic [4:0] rs);
    int lat;
    logic exp_raw;
`ifdef FPSEQ_PERF_EN
    logic [31:0] pb0, pw0;
`endif
    lat = lat_of(op);
    exp_raw = (rd != 5'd0) && (rs == rd);
    issue_valid = 1'b1; issue_op = op; issue_rd = rd; rs1_d = 5'd0; rs2_d = rs;
    #1;
    check("ready_before_issue", 32'(issue_ready), 32'd1);
    check("no_struct_idle", 32'(struct_stall), 32'd0);
`ifdef FPSEQ_PERF_EN
    pb0 = perf_busy_cycles; pw0 = perf_wb_wait_cycles;
`endif
    tick();
    exp_q.push_back(rd);
    starts_exp++;
    for (int k = 1; k <= lat; k++) begin
      issue_valid = (k == 2);
      flush_e = (k == 3);
      #1;
      check("busy_in_busy", 32'(busy), 32'd1);
      check("fpu_start", 32'(fpu_start), 32'(k == 1));
      check("fpu_op", 32'(fpu_op), 32'(op));
      check("wb_valid_in_busy", 32'(wb_valid), 32'd0);
      check("raw_stall_busy", 32'(raw_stall), 32'(exp_raw));
      check("struct_stall_busy", 32'(struct_stall), 32'(k == 2));
      tick();
    end
    issue_valid = 1'b0; flush_e = 1'b0;
    for (int w = 0; w < waits; w++) begin
      int_wb_valid = 1'b1; issue_valid = 1'b1;
      #1;
      check("wb_valid_blocked", 32'(wb_valid), 32'd0);
      check("busy_in_wait", 32'(busy), 32'd1);
      check("struct_stall_wb", 32'(struct_stall), 32'd1);
      check("no_start_wb", 32'(fpu_start), 32'd0);
      check("raw_stall_wait", 32'(raw_stall), 32'(exp_raw));
      tick();
    end
    int_wb_valid = 1'b0; issue_valid = 1'b0;
    #1;
    check("wb_valid_grant", 32'(wb_valid), 32'd1);
    check("wb_rd_grant", 32'(wb_rd), 32'(rd));
    check("raw_stall_grant", 32'(raw_stall), 32'(exp_raw));
    check("no_start_grant", 32'(fpu_start), 32'd0);
    tick();
    check("idle_after_grant", 32'(busy), 32'd0);
    check("ready_after_grant", 32'(issue_ready), 32'd1);
    check("raw_cleared", 32'(raw_stall), 32'd0);
    check("wb_valid_after", 32'(wb_valid), 32'd0);
`ifdef FPSEQ_PERF_EN
    check("perf_busy_delta", perf_busy_cycles - pb0, 32'(lat + 1 + waits));
    check("perf_wait_delta", perf_wb_wait_cycles - pw0, 32'(waits));
`endif
  endtask

  initial begin
    tick(); tick();
    check("rst_ready", 32'(issue_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", 32'(issue_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_raw", 32'(raw_stall), 32'd0);
    check("idle_struct", 32'(struct_stall), 32'd0);
    check("idle_wb_rd", 32'(wb_rd), 32'd0);
    check("idle_fpu_op", 32'(fpu_op), 32'd0);
    check("idle_start", 32'(fpu_start), 32'd0);
`ifdef FPSEQ_PERF_EN
    check("idle_perf_busy", perf_busy_cycles, 32'd0);
    check("idle_perf_wait", perf_wb_wait_cycles, 32'd0);
`endif

    run_op(2'b10, 5'd5, 0, 5'd0);
    run_op(2'b00, 5'd3, 2, 5'd0);
    run_op(2'b11, 5'd7, 0, 5'd7);
    run_op(2'b01, 5'd0, 1, 5'd0);
    run_op(2'b10, 5'd12, 1, 5'd12);

    // Flushed issue in IDLE must be dropped.
    issue_valid = 1'b1; issue_op = 2'b11; issue_rd = 5'd9; flush_e = 1'b1;
    tick();
    issue_valid = 1'b0; flush_e = 1'b0;
    #1;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_start", 32'(fpu_start), 32'd0);
    check("flush_ready", 32'(issue_ready), 32'd1);

    // Reset in the middle of an operation abandons it.
    issue_valid = 1'b1; issue_op = 2'b11; issue_rd = 5'd9;
    tick();
    starts_exp++;
    issue_valid = 1'b0;
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(issue_ready), 32'd1);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("after_reset_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      logic [1:0] op;
      logic [4:0] rd;
      op = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      run_op(op, rd, int'($urandom_range(0, 2)), (i % 2 == 0) ? rd : 5'd0);
    end

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("start_count", 32'(starts_seen), 32'(starts_exp));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
